font_rom_arbiter: RTL

Shares the single synchronous character-font ROM among up to NREQ tile text renderers. Each renderer otherwise drives its own `rom_address` and reads `rom_data`. The block grants one requester per cycle in round-robin order, drives the ROM address from a register, and returns the fetched word to the winning requester with a one-hot valid strobe. It sits between the board's tile renderer array and the font ROM instance.

---
 rtl/font_rom_pkg.sv | 22 ++
 rtl/font_rom_arbiter_rr_pick.sv | 31 +++
 rtl/font_rom_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/font_rom_pkg.sv
// Shared constants, width helper and tag type for the font ROM arbiter.
package font_rom_pkg;

    localparam int NREQ_DEF    = 16;
    localparam int AW_DEF      = 10;
    localparam int DW_DEF      = 32;
    localparam int ROM_LAT_DEF = 1;
    localparam int NREQ_MAX    = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // One-hot owner tag, sized for the largest supported requester count.
    typedef logic [NREQ_MAX-1:0] tag_t;

endpackage

// File: rtl/font_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr lands at bit 0,
// take the lowest set bit, then map the offset back to a requester index.
module rr_pick #(
    parameter int NREQ = 16,
    parameter int PW   = 4
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx
);

    logic [2*NREQ-1:0] w_dbl;
    logic [PW:0]       w_off;
    logic [PW+1:0]     w_sum;
    logic              w_any;

    always_comb begin
        w_dbl = {i_req, i_req} >> i_ptr;
        w_any = |w_dbl;
        w_off = '0;
        // Upper half only duplicates the lower half, so the lowest hit is below NREQ.
        for (int j = 2*NREQ - 1; j >= 0; j--) begin
            if (w_dbl[j]) w_off = (PW+1)'(j);
        end
        w_sum = {2'b00, i_ptr} + {1'b0, w_off};
        o_idx = PW'((w_sum >= (PW+2)'(NREQ)) ? (w_sum - (PW+2)'(NREQ)) : w_sum);
        o_gnt = w_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin sharing of one synchronous font ROM among tile renderers; the
// owner of each fetch rides a one-hot tag pipeline matched to the ROM latency.
module font_rom_arbiter
    import font_rom_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [AW-1:0]     rom_address,
    input  logic [DW-1:0]     rom_data,
    output logic [DW-1:0]     rdata,
    output logic [NREQ-1:0]   rvalid
);

    localparam int PW = clog2(NREQ);

    logic [PW-1:0]   r_ptr;
    tag_t            r_tag [ROM_LAT+1];
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_idx;
    logic [AW-1:0]   w_addr_sel;
    logic [PW-1:0]   w_ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign gnt        = w_gnt;
    assign w_addr_sel = addr[w_idx*AW +: AW];
    assign w_ptr_next = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    // Tag stage ROM_LAT lines up with the cycle rom_data is valid for that fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            rom_address <= '0;
            rdata       <= '0;
            rvalid      <= '0;
            for (int i = 0; i <= ROM_LAT; i++) r_tag[i] <= '0;
        end else begin
            if (|w_gnt) begin
                r_ptr       <= w_ptr_next;
                rom_address <= w_addr_sel;
            end
            r_tag[0] <= tag_t'(w_gnt);
            for (int i = 1; i <= ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
            rvalid <= r_tag[ROM_LAT][NREQ-1:0];
            if (|r_tag[ROM_LAT]) rdata <= rom_data;
        end
    end

endmodule
